stream_merge: RTL and testbench
===============================

Name: stream_merge

Overview:
- 2-to-1 AXI-stream merger that sits directly upstream of the 1-to-2 router.
- Round-robin arbitrates two sources into one stream.
- Prepends the winning source index as the identity MSB. The router then steers on that bit: 0 goes to port 0, 1 goes to port 1.
- Output side is registered; full throughput is one beat per cycle.

Parameters:
- identity_width, 2: width of per-source identity. Output identity is identity_width+1 bits.
- stream_width, 32: payload width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- axi_s_0_ready  out  1  source 0 accept
- axi_s_0_valid  in  1  source 0 beat present
- axi_s_0_identity  in  identity_width  source 0 identity
- axi_s_0_stream  in  stream_width  source 0 payload
- axi_s_1_ready  out  1  source 1 accept
- axi_s_1_valid  in  1  source 1 beat present
- axi_s_1_identity  in  identity_width  source 1 identity
- axi_s_1_stream  in  stream_width  source 1 payload
- axi_m_ready  in  1  sink accept
- axi_m_valid  out  1  output beat present (registered)
- axi_m_identity  out  identity_width+1  {source index, source identity} (registered)
- axi_m_stream  out  stream_width  payload (registered)

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: axi_m_valid=0, axi_m_identity=0, axi_m_stream=0, priority pointer prio=0 (source 0 preferred).
- Reset gates both axi_s_k_ready to 0 while reset=1.
- Output register FSM, 2 states:
  - EMPTY (axi_m_valid=0)
  - FULL (axi_m_valid=1)
- Transitions:
  - EMPTY -> FULL on an accepted input beat.
  - FULL -> FULL on an accepted input beat while axi_m_ready=1 (back-to-back).
  - FULL -> EMPTY when axi_m_ready=1 and no input is accepted.
  - FULL holds when axi_m_ready=0; output contents are frozen.
- Grant (combinational):
  - both valid: grant = prio.
  - one valid: grant = that source.
  - none valid: no grant.
- Ready: axi_s_k_ready = !reset & (grant==k) & (!axi_m_valid | axi_m_ready). Only the granted source ever sees ready=1.
- Accept: source k is accepted when axi_s_k_valid & axi_s_k_ready. On that edge:
  - axi_m_identity <= {k, axi_s_k_identity}
  - axi_m_stream <= axi_s_k_stream
  - axi_m_valid <= 1
  - prio <= ~k
- Latency: a beat accepted at edge N is presented on the output from cycle N+1.
- Sustained throughput is 1 beat/cycle with axi_m_ready held at 1.
- Fairness: when both sources stay valid, grants alternate 0,1,0,1. No source waits more than one beat.
- Stall: while axi_m_ready=0 and FULL, both input readies are 0 and the grant may change. AXI rules hold because readiness, not valid, changes.
- Simultaneous accept and drain: in FULL with axi_m_ready=1 and an input accepted, the register reloads on the same edge. axi_m_valid stays 1 with no bubble.
- prio updates only on an accepted beat. Idle cycles and stalls leave it unchanged.
- Reset mid-operation: an in-flight output beat is discarded, and axi_m_valid is 0 from the next cycle. Upstream sources must re-present their beats.
- Data path: no arithmetic. The identity concatenation is an exact width of identity_width+1.

Decomposition:
- Shared package stream_pkg holds:
  - localparam SRC0=1'b0, SRC1=1'b1
  - FSM state enum {EMPTY, FULL}
  - beat struct {identity, stream}, reusable by the router.
- One natural sub-module: rr_arbiter2, a 2-request round-robin with a prio flop, grant output and advance input.
- Estimated RTL size is around 150 lines.

Test Plan:
1. Reset held 3 cycles with both sources valid -> readies 0, axi_m_valid 0, outputs 0. Then release: first grant goes to source 0, giving axi_m_identity=3'b0xx.
2. Source 0 only, identity=2'b10, stream=0xDEADBEEF, axi_m_ready=1 -> next cycle axi_m_valid=1, axi_m_identity=3'b010, axi_m_stream=0xDEADBEEF.
3. Both sources valid continuously, 8 beats, axi_m_ready=1 -> output MSB sequence 0,1,0,1,0,1,0,1, with valid high every cycle after the first.
4. axi_m_ready=0 for 5 cycles while FULL with source 1 valid -> axi_s_1_ready=0 and outputs stable. When ready returns, the held beat drains and source 1's beat loads on the same edge.
5. Source 1 alone, 3 beats, then source 0 joins -> prio=0 after a source 1 accept, so the next grant is source 0, then alternation.
6. Reset asserted while FULL and stalled -> axi_m_valid=0 on the next cycle and prio=0. No stale beat appears after release.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream definitions used by the merger and the downstream router.
// Source indices, output-register states and the default beat layout.
package stream_pkg;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int IDENTITY_W = 2;
    localparam int STREAM_W   = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Identity carries the prepended source index as its MSB.
    typedef struct packed {
        logic [IDENTITY_W:0]   identity;
        logic [STREAM_W-1:0]   stream;
    } beat_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the priority pointer moves past the
// winner only when the caller reports that the grant was consumed.
module rr_arbiter2
    import stream_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic request_0,
    input  logic request_1,
    input  logic advance,
    output logic grant,
    output logic grant_valid
);

    logic prio;

    always_comb begin
        grant_valid = request_0 | request_1;
        if (request_0 && request_1) begin
            grant = prio;
        end else if (request_1) begin
            grant = SRC1;
        end else begin
            grant = SRC0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio <= SRC0;
        end else if (advance) begin
            prio <= ~grant;
        end
    end

endmodule

// File: rtl/stream_merge.sv
// 2-to-1 round-robin AXI-stream merger with a registered output stage;
// the winning source index is prepended as the identity MSB.
module stream_merge
    import stream_pkg::*;
#(
    parameter int identity_width = 2,
    parameter int stream_width   = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      axi_s_0_ready,
    input  logic                      axi_s_0_valid,
    input  logic [identity_width-1:0] axi_s_0_identity,
    input  logic [stream_width-1:0]   axi_s_0_stream,
    output logic                      axi_s_1_ready,
    input  logic                      axi_s_1_valid,
    input  logic [identity_width-1:0] axi_s_1_identity,
    input  logic [stream_width-1:0]   axi_s_1_stream,
    input  logic                      axi_m_ready,
    output logic                      axi_m_valid,
    output logic [identity_width:0]   axi_m_identity,
    output logic [stream_width-1:0]   axi_m_stream
);

    state_t state;
    logic   grant;
    logic   grant_valid;
    logic   can_load;
    logic   accept_0;
    logic   accept_1;
    logic   accept;

    rr_arbiter2 u_arbiter (
        .clock       (clock),
        .reset       (reset),
        .request_0   (axi_s_0_valid),
        .request_1   (axi_s_1_valid),
        .advance     (accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Register can take a new beat when empty or draining this cycle.
    always_comb begin
        can_load      = (state == EMPTY) || axi_m_ready;
        axi_s_0_ready = !reset && grant_valid && (grant == SRC0) && can_load;
        axi_s_1_ready = !reset && grant_valid && (grant == SRC1) && can_load;
        accept_0      = axi_s_0_valid && axi_s_0_ready;
        accept_1      = axi_s_1_valid && axi_s_1_ready;
        accept        = accept_0 || accept_1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= EMPTY;
            axi_m_identity <= '0;
            axi_m_stream   <= '0;
        end else if (accept_0) begin
            state          <= FULL;
            axi_m_identity <= {SRC0, axi_s_0_identity};
            axi_m_stream   <= axi_s_0_stream;
        end else if (accept_1) begin
            state          <= FULL;
            axi_m_identity <= {SRC1, axi_s_1_identity};
            axi_m_stream   <= axi_s_1_stream;
        end else if (state == FULL && axi_m_ready) begin
            state          <= EMPTY;
        end
    end

    assign axi_m_valid = (state == FULL);

endmodule

// File: tb/tb_stream_merge.sv
// Directed bench for stream_merge: reset, single source, fairness,
// stall with same-edge reload, pointer behaviour and mid-stream reset.
module tb_stream_merge;

    logic        clock;
    logic        reset;
    logic        axi_s_0_ready;
    logic        axi_s_0_valid;
    logic [1:0]  axi_s_0_identity;
    logic [31:0] axi_s_0_stream;
    logic        axi_s_1_ready;
    logic        axi_s_1_valid;
    logic [1:0]  axi_s_1_identity;
    logic [31:0] axi_s_1_stream;
    logic        axi_m_ready;
    logic        axi_m_valid;
    logic [2:0]  axi_m_identity;
    logic [31:0] axi_m_stream;

    int checks;
    int errors;

    stream_merge #(.identity_width(2), .stream_width(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .axi_s_0_ready    (axi_s_0_ready),
        .axi_s_0_valid    (axi_s_0_valid),
        .axi_s_0_identity (axi_s_0_identity),
        .axi_s_0_stream   (axi_s_0_stream),
        .axi_s_1_ready    (axi_s_1_ready),
        .axi_s_1_valid    (axi_s_1_valid),
        .axi_s_1_identity (axi_s_1_identity),
        .axi_s_1_stream   (axi_s_1_stream),
        .axi_m_ready      (axi_m_ready),
        .axi_m_valid      (axi_m_valid),
        .axi_m_identity   (axi_m_identity),
        .axi_m_stream     (axi_m_stream)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        axi_s_0_valid = 1'b0;
        axi_s_1_valid = 1'b0;
        axi_m_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        axi_s_0_valid = 1'b1; axi_s_0_identity = 2'b01; axi_s_0_stream = 32'hAAAA_0001;
        axi_s_1_valid = 1'b1; axi_s_1_identity = 2'b11; axi_s_1_stream = 32'hBBBB_0001;
        axi_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (axi_s_0_ready !== 1'b0 || axi_s_1_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready cycle %0d: got %b%b expected 00", i, axi_s_0_ready, axi_s_1_ready);
            end
            checks++;
            if (axi_m_valid !== 1'b0 || axi_m_identity !== 3'b000 || axi_m_stream !== 32'h0) begin
                errors++;
                $display("FAIL reset_out cycle %0d: got v=%b id=%b s=%h expected v=0 id=000 s=0",
                         i, axi_m_valid, axi_m_identity, axi_m_stream);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (axi_s_0_ready !== 1'b1 || axi_s_1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got ready %b%b expected s0=1 s1=0", axi_s_0_ready, axi_s_1_ready);
        end
        tick();
        checks++;
        if (axi_m_valid !== 1'b1 || axi_m_identity !== 3'b001 || axi_m_stream !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL reset_first_beat: got v=%b id=%b s=%h expected v=1 id=001 s=aaaa0001",
                     axi_m_valid, axi_m_identity, axi_m_stream);
        end
        axi_s_0_valid = 1'b0;
        axi_s_1_valid = 1'b0;
        tick();
        checks++;
        if (axi_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: got v=%b expected 0", axi_m_valid);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        axi_s_0_valid = 1'b1; axi_s_0_identity = 2'b10; axi_s_0_stream = 32'hDEAD_BEEF;
        axi_m_ready = 1'b1;
        #1;
        checks++;
        if (axi_s_0_ready !== 1'b1 || axi_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre: got ready=%b v=%b expected ready=1 v=0", axi_s_0_ready, axi_m_valid);
        end
        tick();
        axi_s_0_valid = 1'b0;
        checks++;
        if (axi_m_valid !== 1'b1 || axi_m_identity !== 3'b010 || axi_m_stream !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_beat: got v=%b id=%b s=%h expected v=1 id=010 s=deadbeef",
                     axi_m_valid, axi_m_identity, axi_m_stream);
        end
        tick();
        checks++;
        if (axi_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got v=%b expected 0", axi_m_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_id;
        logic [31:0] exp_s;
        do_reset();
        axi_s_0_valid = 1'b1; axi_s_0_identity = 2'b01; axi_s_0_stream = 32'h0000_1000;
        axi_s_1_valid = 1'b1; axi_s_1_identity = 2'b10; axi_s_1_stream = 32'h0000_2000;
        axi_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_id = (i % 2 == 0) ? 3'b001 : 3'b110;
            exp_s  = (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
            checks++;
            if (axi_m_valid !== 1'b1 || axi_m_identity !== exp_id || axi_m_stream !== exp_s) begin
                errors++;
                $display("FAIL b2b beat %0d: got v=%b id=%b s=%h expected v=1 id=%b s=%h",
                         i, axi_m_valid, axi_m_identity, axi_m_stream, exp_id, exp_s);
            end
        end
        axi_s_0_valid = 1'b0;
        axi_s_1_valid = 1'b0;
        tick();
        checks++;
        if (axi_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b expected 0", axi_m_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        axi_s_0_valid = 1'b1; axi_s_0_identity = 2'b01; axi_s_0_stream = 32'h0000_0011;
        axi_m_ready = 1'b1;
        tick();
        axi_s_0_valid = 1'b0;
        axi_s_1_valid = 1'b1; axi_s_1_identity = 2'b10; axi_s_1_stream = 32'h0000_0022;
        axi_m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (axi_s_1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready cycle %0d: got %b expected 0", i, axi_s_1_ready);
            end
            tick();
            checks++;
            if (axi_m_valid !== 1'b1 || axi_m_identity !== 3'b001 || axi_m_stream !== 32'h0000_0011) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got v=%b id=%b s=%h expected v=1 id=001 s=00000011",
                         i, axi_m_valid, axi_m_identity, axi_m_stream);
            end
        end
        axi_m_ready = 1'b1;
        #1;
        checks++;
        if (axi_s_1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b expected 1", axi_s_1_ready);
        end
        tick();
        axi_s_1_valid = 1'b0;
        checks++;
        if (axi_m_valid !== 1'b1 || axi_m_identity !== 3'b110 || axi_m_stream !== 32'h0000_0022) begin
            errors++;
            $display("FAIL stall_reload: got v=%b id=%b s=%h expected v=1 id=110 s=00000022",
                     axi_m_valid, axi_m_identity, axi_m_stream);
        end
        tick();
        checks++;
        if (axi_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got v=%b expected 0", axi_m_valid);
        end
    endtask

    task automatic test_prio_after_src1();
        logic [2:0] exp_id;
        do_reset();
        axi_m_ready = 1'b1;
        axi_s_1_valid = 1'b1; axi_s_1_identity = 2'b11;
        for (int i = 0; i < 3; i++) begin
            axi_s_1_stream = 32'h0000_0100 + i;
            tick();
            checks++;
            if (axi_m_identity !== 3'b111 || axi_m_stream !== 32'h0000_0100 + i) begin
                errors++;
                $display("FAIL prio_src1 beat %0d: got id=%b s=%h expected id=111 s=%h",
                         i, axi_m_identity, axi_m_stream, 32'h0000_0100 + i);
            end
        end
        axi_s_0_valid = 1'b1; axi_s_0_identity = 2'b00; axi_s_0_stream = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_id = (i % 2 == 0) ? 3'b000 : 3'b111;
            checks++;
            if (axi_m_valid !== 1'b1 || axi_m_identity !== exp_id) begin
                errors++;
                $display("FAIL prio_join beat %0d: got v=%b id=%b expected v=1 id=%b",
                         i, axi_m_valid, axi_m_identity, exp_id);
            end
        end
        axi_s_0_valid = 1'b0;
        axi_s_1_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        axi_s_0_valid = 1'b1; axi_s_0_identity = 2'b01; axi_s_0_stream = 32'h0000_0AAA;
        axi_s_1_valid = 1'b1; axi_s_1_identity = 2'b10; axi_s_1_stream = 32'h0000_0BBB;
        axi_m_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (axi_s_0_ready !== 1'b0 || axi_s_1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: got %b%b expected 00", axi_s_0_ready, axi_s_1_ready);
        end
        tick();
        checks++;
        if (axi_m_valid !== 1'b0 || axi_m_identity !== 3'b000 || axi_m_stream !== 32'h0) begin
            errors++;
            $display("FAIL midreset_out: got v=%b id=%b s=%h expected v=0 id=000 s=0",
                     axi_m_valid, axi_m_identity, axi_m_stream);
        end
        reset = 1'b0;
        axi_m_ready = 1'b1;
        axi_s_0_stream = 32'h0000_0CCC;
        #1;
        checks++;
        if (axi_s_0_ready !== 1'b1 || axi_s_1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_prio: got ready %b%b expected s0=1 s1=0", axi_s_0_ready, axi_s_1_ready);
        end
        tick();
        axi_s_0_valid = 1'b0;
        axi_s_1_valid = 1'b0;
        checks++;
        if (axi_m_valid !== 1'b1 || axi_m_identity !== 3'b001 || axi_m_stream !== 32'h0000_0CCC) begin
            errors++;
            $display("FAIL midreset_fresh: got v=%b id=%b s=%h expected v=1 id=001 s=00000ccc",
                     axi_m_valid, axi_m_identity, axi_m_stream);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        axi_s_0_valid = 1'b0; axi_s_0_identity = '0; axi_s_0_stream = '0;
        axi_s_1_valid = 1'b0; axi_s_1_identity = '0; axi_s_1_stream = '0;
        axi_m_ready = 1'b0;
        #1;
        test_reset();
        test_single_source();
        test_back_to_back();
        test_stall();
        test_prio_after_src1();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
